// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter slice.
//   next_sel_e : which source feeds the next PC
//   PC_STEP    : sequential fetch increment in bytes
package pc_pkg;

  typedef enum logic [2:0] {
    SEQ,
    BR,
    JMP,
    JR,
    RET
  } next_sel_e;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. Updates on the falling clock edge.
// Ports:
//   clock, reset_n        : clock (falling edge active), async active-low reset
//   push, push_data       : write push_data as the new top entry
//   pop                   : discard the top entry; pop wins if both are requested
//   top                   : current top entry (combinational read)
//   count                 : valid entries, 0..RAS_DEPTH
//   overflow, underflow   : registered one-cycle pulses
module ras_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  // ptr addresses the next free slot; the top entry sits one below it.
  logic [PW-1:0]     ptr;
  logic [ADDR_W-1:0] mem [RAS_DEPTH];

  assign top = mem[ptr - PW'(1)];

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (pop) begin
        if (count == '0) begin
          underflow <= 1'b1;
        end else begin
          ptr   <= ptr - PW'(1);
          count <= count - CW'(1);
        end
      end else if (push) begin
        // A full stack keeps its count; the write lands on the oldest slot.
        ptr <= ptr + PW'(1);
        if (count == CW'(RAS_DEPTH)) begin
          overflow <= 1'b1;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

  // Entry storage needs no reset; only ptr/count define what is valid.
  always_ff @(negedge clock) begin
    if (push && !pop) begin
      mem[ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection with branch, jump, register jump
// and return-address-stack support. State updates on the falling clock edge.
// Ports:
//   clock, reset_n                 : clock, async active-low reset
//   stall                          : freeze PC/RAS, ignore all redirects
//   branch, branch_ne, zero        : conditional branch request and condition
//   branch_target                  : branch destination
//   jump, link, jump_target        : unconditional jump, optional call (push)
//   jr, ret, jr_target             : register jump / return; jr_target also
//                                    serves as ret fallback on an empty RAS
//   pc, pc_plus_4, branch_base_addr: current PC and derived addresses
//   redirect                       : next PC is not the sequential one
//   ras_overflow, ras_underflow    : registered RAS event pulses
//   misalign                       : registered pulse, selected target had [1:0]!=0
module pc_unit
  import pc_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              branch,
  input  logic              branch_ne,
  input  logic              zero,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic              link,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              jr,
  input  logic              ret,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_4,
  output logic [ADDR_W-1:0] branch_base_addr,
  output logic              redirect,
  output logic              ras_overflow,
  output logic              ras_underflow,
  output logic              misalign
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  next_sel_e         sel;
  logic              taken;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] raw_target;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] ras_top;
  logic [CW-1:0]     ras_count;

  assign pc_plus_4        = pc + ADDR_W'(PC_STEP);
  assign branch_base_addr = pc;
  assign taken            = branch & (zero ^ branch_ne);

  always_comb begin
    sel        = SEQ;
    raw_target = pc_plus_4;
    if (ret) begin
      sel        = RET;
      raw_target = (ras_count == '0) ? jr_target : ras_top;
    end else if (jr) begin
      sel        = JR;
      raw_target = jr_target;
    end else if (jump) begin
      sel        = JMP;
      raw_target = jump_target;
    end else if (taken) begin
      sel        = BR;
      raw_target = branch_target;
    end
  end

  // A call is only recorded when no higher-priority ret/jr claims the cycle.
  assign push     = !stall && jump && link && !ret && !jr;
  assign pop      = !stall && ret;
  assign redirect = !stall && (sel != SEQ);

  always_comb begin
    next_pc = pc;
    if (!stall) begin
      next_pc = (sel == SEQ) ? pc_plus_4 : {raw_target[ADDR_W-1:2], 2'b00};
    end
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_VEC;
      misalign <= 1'b0;
    end else begin
      pc       <= next_pc;
      misalign <= !stall && (sel != SEQ) && (raw_target[1:0] != 2'b00);
    end
  end

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus_4),
    .top       (ras_top),
    .count     (ras_count),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clock;
  logic        reset_n;
  logic        stall, branch, branch_ne, zero, jump, link, jr, ret;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] pc, pc_plus_4, branch_base_addr;
  logic        redirect, ras_overflow, ras_underflow, misalign;

  int checks = 0;
  int errors = 0;
  int step_id = 0;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        ovf;
    logic        unf;
    logic        mis;
    logic        redir;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  pc_unit #(
    .ADDR_W    (32),
    .RESET_VEC (32'h0),
    .RAS_DEPTH (4)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .stall            (stall),
    .branch           (branch),
    .branch_ne        (branch_ne),
    .zero             (zero),
    .branch_target    (branch_target),
    .jump             (jump),
    .link             (link),
    .jump_target      (jump_target),
    .jr               (jr),
    .ret              (ret),
    .jr_target        (jr_target),
    .pc               (pc),
    .pc_plus_4        (pc_plus_4),
    .branch_base_addr (branch_base_addr),
    .redirect         (redirect),
    .ras_overflow     (ras_overflow),
    .ras_underflow    (ras_underflow),
    .misalign         (misalign)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  task automatic chk32(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  task automatic chk1(input string name, input int id, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, id, act, exp);
    end
  endtask

  // Monitor: state settles on the falling edge; compare half a cycle later,
  // while the inputs that produced it (and thus redirect) are still applied.
  initial begin
    forever begin
      @(posedge clock);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk32("pc", mon_e.id, pc, mon_e.pc);
        chk32("pc_plus_4", mon_e.id, pc_plus_4, mon_e.pc + 32'd4);
        chk32("branch_base_addr", mon_e.id, branch_base_addr, mon_e.pc);
        chk1("ras_overflow", mon_e.id, ras_overflow, mon_e.ovf);
        chk1("ras_underflow", mon_e.id, ras_underflow, mon_e.unf);
        chk1("misalign", mon_e.id, misalign, mon_e.mis);
        chk1("redirect", mon_e.id, redirect, mon_e.redir);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic st, br, bne, z, input logic [31:0] bt,
                       input logic j, l, input logic [31:0] jt,
                       input logic i_jr, i_ret, input logic [31:0] jrt);
    stall = st; branch = br; branch_ne = bne; zero = z; branch_target = bt;
    jump = j; link = l; jump_target = jt; jr = i_jr; ret = i_ret; jr_target = jrt;
  endtask

  task automatic expect_out(input logic [31:0] epc, input logic eo, eu, em, er);
    exp_t e;
    step_id++;
    e.id = step_id; e.pc = epc; e.ovf = eo; e.unf = eu; e.mis = em; e.redir = er;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic st, br, bne, z, input logic [31:0] bt,
                      input logic j, l, input logic [31:0] jt,
                      input logic i_jr, i_ret, input logic [31:0] jrt,
                      input logic [31:0] epc, input logic eo, eu, em, er);
    @(posedge clock);
    #1;
    drive(st, br, bne, z, bt, j, l, jt, i_jr, i_ret, jrt);
    expect_out(epc, eo, eu, em, er);
  endtask

  task automatic idle(input logic [31:0] epc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, epc, 0, 0, 0, 0);
  endtask

  task automatic jmp(input logic [31:0] jt, input logic l, input logic [31:0] epc,
                     input logic eo, em);
    step(0, 0, 0, 0, 0, 1, l, jt, 0, 0, 0, epc, eo, 0, em, 1);
  endtask

  task automatic brn(input logic bne, z, input logic [31:0] bt, input logic [31:0] epc,
                     input logic er);
    step(0, 1, bne, z, bt, 0, 0, 0, 0, 0, 0, epc, 0, 0, 0, er);
  endtask

  task automatic rt(input logic [31:0] jrt, input logic [31:0] epc, input logic eu);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, jrt, epc, 0, eu, 0, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk32("reset_pc", 0, pc, 32'h0);
    chk1("reset_ovf", 0, ras_overflow, 1'b0);
    chk1("reset_unf", 0, ras_underflow, 1'b0);
    chk1("reset_mis", 0, misalign, 1'b0);

    @(posedge clock);
    #1;
    reset_n = 1'b1;
    expect_out(32'h4, 0, 0, 0, 0);
    idle(32'h8);
    idle(32'hC);
    idle(32'h10);

    // branch condition table from pc=0x10
    brn(0, 1, 32'h40, 32'h40, 1);
    jmp(32'h10, 0, 32'h10, 0, 0);
    brn(0, 0, 32'h40, 32'h14, 0);
    jmp(32'h10, 0, 32'h10, 0, 0);
    brn(1, 0, 32'h40, 32'h40, 1);
    brn(1, 1, 32'h80, 32'h44, 0);

    // priority: jump over branch, jr over jump
    step(0, 1, 0, 1, 32'h40, 1, 0, 32'h80, 0, 0, 0, 32'h80, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 32'hA0, 1, 0, 32'h90, 32'h90, 0, 0, 0, 1);

    // simple call/return
    jmp(32'h100, 0, 32'h100, 0, 0);
    jmp(32'h200, 1, 32'h200, 0, 0);
    idle(32'h204);
    idle(32'h208);
    rt(32'h0, 32'h104, 0);

    // five nested calls into a 4-deep stack
    jmp(32'h300, 1, 32'h300, 0, 0);
    jmp(32'h400, 1, 32'h400, 0, 0);
    jmp(32'h500, 1, 32'h500, 0, 0);
    jmp(32'h600, 1, 32'h600, 0, 0);
    jmp(32'h700, 1, 32'h700, 1, 0);
    idle(32'h704);
    rt(32'hFF0, 32'h604, 0);
    rt(32'hFF0, 32'h504, 0);
    rt(32'hFF0, 32'h404, 0);
    rt(32'hFF0, 32'h304, 0);
    rt(32'h300, 32'h300, 1);
    idle(32'h304);

    // ret together with jal: single pop, no push
    jmp(32'h800, 1, 32'h800, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h900, 0, 1, 32'hFF0, 32'h308, 0, 0, 0, 1);
    rt(32'h350, 32'h350, 1);

    // stall holds PC and RAS
    jmp(32'hA00, 1, 32'hA00, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 32'hB00, 0, 0, 0, 32'hA00, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 32'hB00, 0, 0, 0, 32'hA00, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 32'hB00, 0, 0, 0, 32'hA00, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFF0, 32'hA00, 0, 0, 0, 0);
    jmp(32'h203, 0, 32'h200, 0, 1);
    idle(32'h204);
    rt(32'hFF0, 32'h354, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h302, 32'h300, 0, 0, 1, 1);

    // address wrap
    jmp(32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 0);
    idle(32'h0);
    idle(32'h4);
    jmp(32'h40, 1, 32'h40, 0, 0);

    // async reset during a pending call
    @(posedge clock);
    #1;
    drive(0, 0, 0, 0, 0, 1, 1, 32'h600, 0, 0, 0);
    #1;
    reset_n = 1'b0;
    #1;
    chk32("async_reset_pc", step_id, pc, 32'h0);
    chk1("async_reset_mis", step_id, misalign, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out(32'h4, 0, 0, 0, 0);
    rt(32'h300, 32'h300, 1);
    idle(32'h304);

    @(posedge clock);
    #1;
    chk32("queue_drained", step_id, exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, default 32: width of every address port and the PC register.
REQ-002 Parameter RESET_VEC, default 0: PC value loaded on reset; low 2 bits SHALL be 0.
REQ-003 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of 2, at least 2.
REQ-004 clock  input  1  single clock; PC and RAS update on its falling edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  hold PC and RAS; all redirect requests ignored this cycle.
REQ-007 branch  input  1  conditional branch instruction present.
REQ-008 branch_ne  input  1  0 = taken when zero=1 (beq); 1 = taken when zero=0 (bne).
REQ-009 zero  input  1  ALU equality result.
REQ-010 branch_target  input  ADDR_W  ALU-computed branch address.
REQ-011 jump  input  1  unconditional jump to jump_target.
REQ-012 link  input  1  with jump: push pc+4 onto RAS (jal).
REQ-013 jump_target  input  ADDR_W  absolute jump address.
REQ-014 jr  input  1  register-indirect jump to jr_target.
REQ-015 ret  input  1  return: jump to RAS top, pop.
REQ-016 jr_target  input  ADDR_W  register-file value; fallback target for ret on empty RAS.
REQ-017 pc  output  ADDR_W  current PC (registered).
REQ-018 pc_plus_4  output  ADDR_W  pc+4, combinational, modulo 2^ADDR_W.
REQ-019 branch_base_addr  output  ADDR_W  equals pc.
REQ-020 redirect  output  1  combinational; 1 when next PC is not pc+4 and stall=0.
REQ-021 ras_overflow  output  1  registered, one-cycle pulse when a push overwrote the oldest entry.
REQ-022 ras_underflow  output  1  registered, one-cycle pulse when ret hit an empty RAS.
REQ-023 misalign  output  1  registered, one-cycle pulse when the selected target had nonzero bits [1:0].

Function
REQ-024 Next-PC priority, stall=0: ret > jr > jump > taken branch > pc+4.
REQ-025 Branch taken SHALL equal branch & (zero ^ branch_ne).
REQ-026 Any selected target SHALL be loaded with bits [1:0] forced to 00; misalign pulses the following cycle if the raw bits were nonzero.
REQ-027 jump & link & no ret/jr SHALL push pc+4 (pre-update PC) onto RAS; link without jump SHALL be ignored.
REQ-028 ret with count>0: next PC = top entry; pointer decrements; count decrements.
REQ-029 ret with count=0: next PC = jr_target; RAS unchanged; ras_underflow pulses.
REQ-030 Push with count=RAS_DEPTH: pointer wraps modulo RAS_DEPTH, oldest entry is overwritten, count stays RAS_DEPTH, ras_overflow pulses.
REQ-031 ret together with jump&link: ret wins; no push; single pop only.
REQ-032 stall=1: pc, RAS, pointer and count hold; flag outputs deassert next edge; redirect=0.
REQ-033 pc+4 at 2^ADDR_W-4 SHALL wrap to 0 without a flag.
REQ-034 Latency: pc SHALL reflect the decision on the first falling edge after the request.

Reset
REQ-035 reset_n=0 SHALL immediately set pc=RESET_VEC, RAS count=0, pointer=0, ras_overflow=ras_underflow=misalign=0; RAS data contents are don't-care.
REQ-036 A reset asserted mid-operation SHALL discard any pending push or pop; the first edge after release performs normal next-PC selection.

Structure
REQ-037 Shared package pc_pkg SHALL hold the next-PC select enum (SEQ, BR, JMP, JR, RET) and the constant PC_STEP=4.
REQ-038 RAS SHALL be a separate sub-module ras_stack (push, pop, top, count, overflow, underflow), parametrised by ADDR_W and RAS_DEPTH.

Verification
REQ-039 Release reset with defaults -> pc=0; three free-running cycles -> pc=4, 8, 12.
REQ-040 pc=0x10, branch=1, branch_ne=0, zero=1, branch_target=0x40 -> pc=0x40; same with zero=0 -> pc=0x14; branch_ne=1, zero=0 -> pc=0x40.
REQ-041 At pc=0x100, jal (jump=1, link=1, jump_target=0x200), then ret at 0x208 -> pc=0x104; 5 nested jal with RAS_DEPTH=4 -> ras_overflow pulses once; 4 rets return to the last 4 link addresses.
REQ-042 ret with empty RAS, jr_target=0x300 -> pc=0x300, ras_underflow=1 for exactly one cycle.
REQ-043 stall=1 with jump=1 for 3 cycles -> pc and RAS unchanged, redirect=0; jump_target=0x203 with stall=0 -> pc=0x200, misalign pulses.
REQ-044 reset_n low between clock edges during a pending jal -> pc=RESET_VEC immediately, RAS count=0 after release.
